ram_burst_ctrl: RTL and testbench
=================================

RAM_BURST_CTRL -- requirements
Module: ram_burst_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 64, RAM row width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH, default 512, RAM rows; AW = ceil(log2(DEPTH)).
REQ-003 SHALL have port CLK  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port RSTN  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port CMD_VALID  in  1  burst command valid.
REQ-006 SHALL have port CMD_READY  out  1  command accepted when high with CMD_VALID.
REQ-007 SHALL have port CMD_WRITE  in  1  1 = write burst, 0 = read burst.
REQ-008 SHALL have port CMD_ADDR  in  AW  first row.
REQ-009 SHALL have port CMD_LEN  in  AW+1  rows in burst, legal 1..DEPTH.
REQ-010 SHALL have port WR_VALID  in  1  write-data beat valid.
REQ-011 SHALL have port WR_READY  out  1  write-data beat accepted.
REQ-012 SHALL have port WR_DATA  in  WIDTH  write row data.
REQ-013 SHALL have port WR_STRB  in  WIDTH/8  per-byte write enables.
REQ-014 SHALL have port RD_VALID  out  1  read-data beat valid.
REQ-015 SHALL have port RD_READY  in  1  downstream accepts read beat.
REQ-016 SHALL have port RD_DATA  out  WIDTH  read row data.
REQ-017 SHALL have port RD_LAST  out  1  marks final beat of a read burst.
REQ-018 SHALL have port DONE  out  1  one-cycle pulse, burst completed.
REQ-019 SHALL have port ERR  out  1  one-cycle pulse, command rejected.
REQ-020 SHALL have port RAM_ADDR  out  AW  RAM port row address.
REQ-021 SHALL have port RAM_REN  out  1  RAM read enable.
REQ-022 SHALL have port RAM_RVALID  in  1  RAM read data valid, one cycle after RAM_REN.
REQ-023 SHALL have port RAM_RDATA  in  WIDTH  RAM read data.
REQ-024 SHALL have ports RAM_WEN out 1, RAM_WDATA out WIDTH, RAM_WSTRB out WIDTH/8: RAM write enable, data, byte strobes.

Function
REQ-025 SHALL implement FSM states IDLE, WR, RD_ISSUE, RD_DRAIN, DONE; CMD_READY high only in IDLE.
REQ-026 SHALL, on CMD handshake with CMD_LEN=0 or CMD_ADDR+CMD_LEN>DEPTH (see REQ-040), pulse ERR next cycle, stay IDLE, issue no RAM access.
REQ-027 SHALL, on legal write command, enter WR; WR_READY high only in WR; each WR handshake drives registered RAM_WEN=1, RAM_ADDR, RAM_WDATA, RAM_WSTRB the following cycle.
REQ-028 SHALL increment the row address by one per beat; after the CMD_LEN-th beat go to DONE.
REQ-029 SHALL, on legal read command, enter RD_ISSUE and drive registered RAM_REN=1 with incrementing RAM_ADDR while credit is available.
REQ-030 SHALL buffer RAM_RDATA in a 4-entry FIFO; credits = 4 minus (reads in flight + FIFO occupancy); RAM_REN only when credits>0; never overflow.
REQ-031 SHALL present FIFO head on RD_VALID/RD_DATA, first beat the cycle after RAM_RVALID; sustain one beat per cycle with RD_READY held high.
REQ-032 SHALL hold RD_DATA/RD_VALID/RD_LAST stable while RD_VALID=1 and RD_READY=0.
REQ-033 SHALL assert RD_LAST with the CMD_LEN-th beat only; go RD_ISSUE->RD_DRAIN after last RAM_REN, RD_DRAIN->DONE after RD_LAST handshake.
REQ-034 SHALL pulse DONE for one cycle in DONE state, then return to IDLE (CMD_READY high next cycle).
REQ-035 SHALL ignore RAM_RVALID when no read is in flight.
REQ-036 SHALL never assert RAM_REN and RAM_WEN in the same cycle.

Reset
REQ-037 SHALL, with RSTN low at a clock edge, go to IDLE, flush FIFO, zero credits, drive CMD_READY, WR_READY, RD_VALID, RD_LAST, DONE, ERR, RAM_REN, RAM_WEN to 0 and RAM_ADDR, RAM_WDATA, RAM_WSTRB, RD_DATA to 0.
REQ-038 SHALL abandon any burst on reset mid-operation with no further RAM access; CMD_READY high the first cycle after RSTN returns high.

Configuration
REQ-039 SHALL use macro RAM_BURST_CTRL_WRAP_EN to select address wrap-around.
REQ-040 SHALL, with the macro defined, accept any CMD_LEN 1..DEPTH and wrap the address DEPTH-1 -> 0; without it, reject bursts crossing DEPTH-1 via ERR.

Verification
REQ-041 SHALL cover: write ADDR=4 LEN=3 strobes all-ones -> RAM_WEN three cycles at rows 4,5,6, DONE one cycle after last RAM_WEN.
REQ-042 SHALL cover: read ADDR=4 LEN=3, RD_READY=1 -> RAM_REN cycles 1-3, RD_VALID cycles 3-5, RD_LAST on cycle 5, DONE cycle 6.
REQ-043 SHALL cover: read LEN=8 with RD_READY low 10 cycles -> exactly 4 RAM_REN, no data loss, 8 beats in order after release.
REQ-044 SHALL cover: CMD_LEN=0, and ADDR=510 LEN=4 with DEPTH=512 -> ERR pulse, no RAM access (without macro); rows 510,511,0,1 (with macro).
REQ-045 SHALL cover: RSTN low during read burst beat 2 -> all outputs 0 next cycle, late RAM_RVALID ignored, new command accepted after reset.

Source files
------------

// File: rtl/ram_burst_ctrl.sv
// ---------------------------------------------------------------------------
// ram_burst_ctrl
//
// Burst controller between a command/stream interface and a single-port,
// one-cycle-latency RAM. A write burst streams WR beats into consecutive RAM
// rows; a read burst issues consecutive RAM reads and streams the returned
// rows out through a 4-entry FIFO, with read issue throttled by credits so
// that the FIFO can never overflow while the consumer stalls.
//
// Optional feature:
//   RAM_BURST_CTRL_WRAP_EN  defined   : bursts may cross row DEPTH-1 and wrap
//                                       to row 0 (any CMD_LEN 1..DEPTH).
//                           undefined : bursts that would cross row DEPTH-1
//                                       are rejected with ERR.
//
// Ports:
//   CLK, RSTN                     clock, synchronous active-low reset
//   CMD_VALID/CMD_READY           burst command handshake
//   CMD_WRITE, CMD_ADDR, CMD_LEN  direction, first row, row count (1..DEPTH)
//   WR_VALID/WR_READY             write-beat handshake
//   WR_DATA, WR_STRB              write row data and byte enables
//   RD_VALID/RD_READY             read-beat handshake
//   RD_DATA, RD_LAST              read row data, final-beat marker
//   DONE, ERR                     one-cycle pulses: burst done / cmd rejected
//   RAM_ADDR, RAM_REN             RAM row address, read enable
//   RAM_RVALID, RAM_RDATA         RAM read return (one cycle after RAM_REN)
//   RAM_WEN, RAM_WDATA, RAM_WSTRB RAM write enable, data, byte strobes
//   DBG_STATE                     current FSM state (IDLE=0, WR=1,
//                                 RD_ISSUE=2, RD_DRAIN=3, DONE=4)
//
// Handshakes (CMD, WR, RD): a transfer happens on a rising CLK edge where
// both valid and ready are high; the source keeps valid and payload stable
// while valid is high and ready is low.
// ---------------------------------------------------------------------------
module ram_burst_ctrl #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 512,
   localparam int AW = $clog2(DEPTH),
   localparam int SW = WIDTH / 8
) (
   input  logic              CLK,
   input  logic              RSTN,
   input  logic              CMD_VALID,
   output logic              CMD_READY,
   input  logic              CMD_WRITE,
   input  logic [AW-1:0]     CMD_ADDR,
   input  logic [AW:0]       CMD_LEN,
   input  logic              WR_VALID,
   output logic              WR_READY,
   input  logic [WIDTH-1:0]  WR_DATA,
   input  logic [SW-1:0]     WR_STRB,
   output logic              RD_VALID,
   input  logic              RD_READY,
   output logic [WIDTH-1:0]  RD_DATA,
   output logic              RD_LAST,
   output logic              DONE,
   output logic              ERR,
   output logic [AW-1:0]     RAM_ADDR,
   output logic              RAM_REN,
   input  logic              RAM_RVALID,
   input  logic [WIDTH-1:0]  RAM_RDATA,
   output logic              RAM_WEN,
   output logic [WIDTH-1:0]  RAM_WDATA,
   output logic [SW-1:0]     RAM_WSTRB,
   output logic [2:0]        DBG_STATE
);

   localparam int LW = AW + 1;   // width of row counts
   localparam int EW = AW + 2;   // width wide enough for ADDR+LEN

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WR       = 3'd1,
      S_RD_ISSUE = 3'd2,
      S_RD_DRAIN = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t            state;
   logic [AW-1:0]     addr;        // next row to access
   logic [LW-1:0]     issue_left;  // read rows not yet issued to the RAM
   logic [LW-1:0]     beats_left;  // beats not yet transferred on WR / RD
   logic [2:0]        inflight;    // reads issued whose data has not returned

   logic [WIDTH-1:0]  fifo_mem [4];
   logic [1:0]        wptr;
   logic [1:0]        rptr;
   logic [2:0]        fifo_cnt;

   logic              cmd_fire;
   logic              cmd_bad;
   logic              cmd_rd_go;
   logic              rd_issue;
   logic              ren_next;
   logic              can_issue;
   logic              rd_push;
   logic              rd_pop;
   logic [2:0]        inflight_nxt;
   logic [2:0]        fifo_cnt_nxt;

   function automatic logic [AW-1:0] next_row(input logic [AW-1:0] a);
      if (a == AW'(DEPTH - 1)) next_row = '0;
      else                     next_row = a + AW'(1);
   endfunction

   // Command legality
`ifdef RAM_BURST_CTRL_WRAP_EN
   assign cmd_bad = (CMD_LEN == '0) ||
                    ({1'b0, CMD_LEN} > EW'(DEPTH)) ||
                    ({2'b00, CMD_ADDR} >= EW'(DEPTH));
`else
   logic [EW-1:0] cmd_end;
   assign cmd_end = {2'b00, CMD_ADDR} + {1'b0, CMD_LEN};
   assign cmd_bad = (CMD_LEN == '0) || (cmd_end > EW'(DEPTH));
`endif

   assign cmd_fire  = (state == S_IDLE) && CMD_VALID && CMD_READY;
   assign cmd_rd_go = cmd_fire && !cmd_bad && !CMD_WRITE;

   // A read slot is free when in-flight reads plus buffered rows leave room
   // in the FIFO. Pops in the current cycle are not credited until the next
   // cycle, which keeps the check conservative without costing throughput.
   assign can_issue = ({1'b0, inflight} + {1'b0, fifo_cnt}) < 4'd4;
   assign rd_issue  = (state == S_RD_ISSUE) && (issue_left != '0) && can_issue;
   assign ren_next  = rd_issue || cmd_rd_go;

   // Stray returns with nothing outstanding are dropped.
   assign rd_push = RAM_RVALID && (inflight != 3'd0);
   assign rd_pop  = (fifo_cnt != 3'd0) && RD_READY;

   always_comb begin
      inflight_nxt = inflight;
      if (ren_next) inflight_nxt = inflight_nxt + 3'd1;
      if (rd_push)  inflight_nxt = inflight_nxt - 3'd1;
   end

   always_comb begin
      fifo_cnt_nxt = fifo_cnt;
      if (rd_push) fifo_cnt_nxt = fifo_cnt_nxt + 3'd1;
      if (rd_pop)  fifo_cnt_nxt = fifo_cnt_nxt - 3'd1;
   end

   // FIFO head drives the read stream; data reads as zero when empty so the
   // bus is clean after reset.
   assign RD_VALID  = (fifo_cnt != 3'd0);
   assign RD_DATA   = (fifo_cnt != 3'd0) ? fifo_mem[rptr] : '0;
   assign RD_LAST   = (fifo_cnt != 3'd0) && (beats_left == LW'(1));
   assign DBG_STATE = state;

   always_ff @(posedge CLK) begin
      if (rd_push) fifo_mem[wptr] <= RAM_RDATA;
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state      <= S_IDLE;
         addr       <= '0;
         issue_left <= '0;
         beats_left <= '0;
         inflight   <= 3'd0;
         wptr       <= 2'd0;
         rptr       <= 2'd0;
         fifo_cnt   <= 3'd0;
         CMD_READY  <= 1'b0;
         WR_READY   <= 1'b0;
         DONE       <= 1'b0;
         ERR        <= 1'b0;
         RAM_REN    <= 1'b0;
         RAM_WEN    <= 1'b0;
         RAM_ADDR   <= '0;
         RAM_WDATA  <= '0;
         RAM_WSTRB  <= '0;
      end else begin
         RAM_REN  <= 1'b0;
         RAM_WEN  <= 1'b0;
         DONE     <= 1'b0;
         ERR      <= 1'b0;
         inflight <= inflight_nxt;
         fifo_cnt <= fifo_cnt_nxt;
         if (rd_push) wptr <= wptr + 2'd1;
         if (rd_pop)  rptr <= rptr + 2'd1;

         case (state)
            S_IDLE: begin
               if (cmd_fire) begin
                  if (cmd_bad) begin
                     ERR <= 1'b1;
                  end else if (CMD_WRITE) begin
                     state      <= S_WR;
                     CMD_READY  <= 1'b0;
                     WR_READY   <= 1'b1;
                     addr       <= CMD_ADDR;
                     beats_left <= CMD_LEN;
                  end else begin
                     // First read goes out on the accept edge.
                     state      <= S_RD_ISSUE;
                     CMD_READY  <= 1'b0;
                     RAM_REN    <= 1'b1;
                     RAM_ADDR   <= CMD_ADDR;
                     addr       <= next_row(CMD_ADDR);
                     issue_left <= CMD_LEN - LW'(1);
                     beats_left <= CMD_LEN;
                  end
               end else begin
                  CMD_READY <= 1'b1;
               end
            end

            S_WR: begin
               if (WR_READY && WR_VALID) begin
                  RAM_WEN    <= 1'b1;
                  RAM_ADDR   <= addr;
                  RAM_WDATA  <= WR_DATA;
                  RAM_WSTRB  <= WR_STRB;
                  addr       <= next_row(addr);
                  beats_left <= beats_left - LW'(1);
                  if (beats_left == LW'(1)) WR_READY <= 1'b0;
               end else if (!WR_READY) begin
                  // Last RAM write is on the bus this cycle; finish next.
                  state <= S_DONE;
                  DONE  <= 1'b1;
               end
            end

            S_RD_ISSUE: begin
               if (rd_pop) beats_left <= beats_left - LW'(1);
               if (rd_issue) begin
                  RAM_REN    <= 1'b1;
                  RAM_ADDR   <= addr;
                  addr       <= next_row(addr);
                  issue_left <= issue_left - LW'(1);
                  if (issue_left == LW'(1)) state <= S_RD_DRAIN;
               end else if (issue_left == '0) begin
                  state <= S_RD_DRAIN;
               end
            end

            S_RD_DRAIN: begin
               if (rd_pop) begin
                  beats_left <= beats_left - LW'(1);
                  if (beats_left == LW'(1)) begin
                     state <= S_DONE;
                     DONE  <= 1'b1;
                  end
               end
            end

            S_DONE: begin
               state     <= S_IDLE;
               CMD_READY <= 1'b1;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Testbench for ram_burst_ctrl with a behavioural one-cycle-latency RAM.
module tb_ram_burst_ctrl;

   localparam int AW = 9;

   logic          clk = 1'b0;
   logic          rstn;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [AW:0]   cmd_len;
   logic          wr_valid, wr_ready;
   logic [63:0]   wr_data;
   logic [7:0]    wr_strb;
   logic          rd_valid, rd_ready, rd_last;
   logic [63:0]   rd_data;
   logic          done, err;
   logic [AW-1:0] ram_addr;
   logic          ram_ren, ram_rvalid, ram_wen;
   logic [63:0]   ram_rdata, ram_wdata;
   logic [7:0]    ram_wstrb;
   logic [2:0]    dbg_state;

   int total = 0;
   int bad   = 0;
   logic [63:0] exp_q[$];
   logic [63:0] got_q[$];

   ram_burst_ctrl dut (
      .CLK(clk), .RSTN(rstn),
      .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WRITE(cmd_write),
      .CMD_ADDR(cmd_addr), .CMD_LEN(cmd_len),
      .WR_VALID(wr_valid), .WR_READY(wr_ready), .WR_DATA(wr_data), .WR_STRB(wr_strb),
      .RD_VALID(rd_valid), .RD_READY(rd_ready), .RD_DATA(rd_data), .RD_LAST(rd_last),
      .DONE(done), .ERR(err),
      .RAM_ADDR(ram_addr), .RAM_REN(ram_ren), .RAM_RVALID(ram_rvalid), .RAM_RDATA(ram_rdata),
      .RAM_WEN(ram_wen), .RAM_WDATA(ram_wdata), .RAM_WSTRB(ram_wstrb),
      .DBG_STATE(dbg_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // RAM model
   logic [63:0] mem [512];
   logic        m_rvalid;
   logic [63:0] m_rdata;
   logic        rv_force;

   always @(posedge clk) begin
      m_rvalid <= ram_ren;
      if (ram_ren) m_rdata <= mem[ram_addr];
      if (ram_wen)
         for (int b = 0; b < 8; b++)
            if (ram_wstrb[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
   end

   assign ram_rvalid = m_rvalid | rv_force;
   assign ram_rdata  = rv_force ? 64'hBAD0_BAD0_BAD0_BAD0 : m_rdata;

   function automatic logic [63:0] pat(input int r);
      logic [15:0] rr;
      rr = r[15:0];
      return {16'hC0DE, rr, 16'hBEEF, ~rr};
   endfunction

   // driver tasks
   task automatic tick();
      @(negedge clk);
   endtask

   // Present a command at this negedge; returns one cycle after the accept edge.
   task automatic start_cmd(input logic w, input int a, input int l);
      int n;
      n = 0;
      while (!cmd_ready && n < 10) begin tick(); n++; end
      total++;
      if (!cmd_ready) begin bad++; $display("FAIL cmd_ready_wait: got 0 want 1"); end
      cmd_write = w;
      cmd_addr  = a[AW-1:0];
      cmd_len   = l[AW:0];
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic do_write(input int a, input int l, input logic [7:0] strb, input logic ones);
      int  b;
      logic hs;
      b = 0; hs = 1'b0;
      wr_valid = 1'b1; wr_strb = strb;
      wr_data = ones ? '1 : pat(a);
      start_cmd(1'b1, a, l);
      for (int i = 0; i < 60; i++) begin
         if (hs) begin
            b++;
            if (b == l) wr_valid = 1'b0;
            else wr_data = ones ? '1 : pat(a + b);
         end
         if (done) break;
         hs = wr_valid && wr_ready;
         tick();
      end
      total++;
      if (!done) begin bad++; $display("FAIL write_done_timeout: got 0 want 1"); end
      wr_valid = 1'b0;
      tick();
   endtask

   task automatic do_read(input int a, input int l);
      rd_ready = 1'b1;
      got_q.delete();
      start_cmd(1'b0, a, l);
      for (int i = 0; i < 80; i++) begin
         if (rd_valid) got_q.push_back(rd_data);
         if (done) break;
         tick();
      end
      total++;
      if (!done) begin bad++; $display("FAIL read_done_timeout: got 0 want 1"); end
      tick();
   endtask

   // scenarios
   task automatic test_reset();
      rstn = 1'b0;
      tick(); tick();
      total++;
      if ({cmd_ready, wr_ready, rd_valid, rd_last, done, err, ram_ren, ram_wen} !== 8'h00) begin
         bad++;
         $display("FAIL reset_ctrl: got %b want 00000000",
                  {cmd_ready, wr_ready, rd_valid, rd_last, done, err, ram_ren, ram_wen});
      end
      total++;
      if ({ram_addr, ram_wdata, ram_wstrb, rd_data} !== '0) begin
         bad++;
         $display("FAIL reset_buses: addr=%h wdata=%h wstrb=%h rdata=%h want 0",
                  ram_addr, ram_wdata, ram_wstrb, rd_data);
      end
      rstn = 1'b1;
      tick();
      total++;
      if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
      total++;
      if (dbg_state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
   endtask

   task automatic test_write();
      int   b;
      logic hs;
      logic exp_wen;
      b = 0; hs = 1'b0;
      wr_valid = 1'b1; wr_strb = 8'hFF; wr_data = pat(4);
      start_cmd(1'b1, 4, 3);
      for (int c = 1; c <= 6; c++) begin
         if (hs) begin
            b++;
            if (b == 3) wr_valid = 1'b0;
            else wr_data = pat(4 + b);
         end
         exp_wen = (c >= 2 && c <= 4);
         total++;
         if (ram_wen !== exp_wen) begin bad++; $display("FAIL wr_wen c%0d: got %b want %b", c, ram_wen, exp_wen); end
         if (exp_wen) begin
            total++;
            if (ram_addr !== 9'(4 + c - 2)) begin bad++; $display("FAIL wr_addr c%0d: got %0d want %0d", c, ram_addr, 4 + c - 2); end
            total++;
            if (ram_wdata !== pat(4 + c - 2)) begin bad++; $display("FAIL wr_data c%0d: got %h want %h", c, ram_wdata, pat(4 + c - 2)); end
         end
         total++;
         if (done !== 1'(c == 5)) begin bad++; $display("FAIL wr_done c%0d: got %b want %b", c, done, c == 5); end
         total++;
         if (ram_ren !== 1'b0) begin bad++; $display("FAIL wr_ren c%0d: got %b want 0", c, ram_ren); end
         if (c == 6) begin
            total++;
            if (cmd_ready !== 1'b1) begin bad++; $display("FAIL wr_cmd_ready: got %b want 1", cmd_ready); end
         end
         hs = wr_valid && wr_ready;
         tick();
      end
   endtask

   task automatic test_read();
      logic exp_ren, exp_v;
      rd_ready = 1'b1;
      start_cmd(1'b0, 4, 3);
      for (int c = 1; c <= 7; c++) begin
         exp_ren = (c >= 1 && c <= 3);
         exp_v   = (c >= 3 && c <= 5);
         total++;
         if (ram_ren !== exp_ren) begin bad++; $display("FAIL rd_ren c%0d: got %b want %b", c, ram_ren, exp_ren); end
         if (exp_ren) begin
            total++;
            if (ram_addr !== 9'(4 + c - 1)) begin bad++; $display("FAIL rd_addr c%0d: got %0d want %0d", c, ram_addr, 4 + c - 1); end
         end
         total++;
         if (rd_valid !== exp_v) begin bad++; $display("FAIL rd_valid c%0d: got %b want %b", c, rd_valid, exp_v); end
         if (exp_v) begin
            total++;
            if (rd_data !== pat(4 + c - 3)) begin bad++; $display("FAIL rd_data c%0d: got %h want %h", c, rd_data, pat(4 + c - 3)); end
         end
         total++;
         if (rd_last !== 1'(c == 5)) begin bad++; $display("FAIL rd_last c%0d: got %b want %b", c, rd_last, c == 5); end
         total++;
         if (done !== 1'(c == 6)) begin bad++; $display("FAIL rd_done c%0d: got %b want %b", c, done, c == 6); end
         total++;
         if (ram_wen !== 1'b0) begin bad++; $display("FAIL rd_wen c%0d: got %b want 0", c, ram_wen); end
         if (c == 7) begin
            total++;
            if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rd_cmd_ready: got %b want 1", cmd_ready); end
         end
         tick();
      end
   endtask

   task automatic test_stall();
      int          stall_ren, total_ren, beats;
      logic        held_v;
      logic [63:0] held_d;
      logic [63:0] want;
      do_write(16, 8, 8'hFF, 1'b0);
      exp_q.delete();
      for (int r = 16; r < 24; r++) exp_q.push_back(pat(r));
      stall_ren = 1; beats = 0; held_v = 1'b0; held_d = '0;
      rd_ready = 1'b0;
      start_cmd(1'b0, 16, 8);
      for (int c = 1; c <= 10; c++) begin
         if (c > 1 && ram_ren) stall_ren++;
         if (held_v) begin
            total++;
            if (rd_valid !== 1'b1 || rd_data !== held_d) begin
               bad++;
               $display("FAIL stall_hold c%0d: got v=%b d=%h want v=1 d=%h", c, rd_valid, rd_data, held_d);
            end
         end else if (rd_valid) begin
            held_v = 1'b1; held_d = rd_data;
         end
         if (c < 10) tick();
      end
      total++;
      if (stall_ren !== 4) begin bad++; $display("FAIL stall_ren_count: got %0d want 4", stall_ren); end
      total_ren = stall_ren;
      rd_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (rd_valid) begin
            want = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            total++;
            if (rd_data !== want) begin bad++; $display("FAIL stall_beat%0d: got %h want %h", beats, rd_data, want); end
            total++;
            if (rd_last !== 1'(beats == 7)) begin bad++; $display("FAIL stall_last%0d: got %b want %b", beats, rd_last, beats == 7); end
            beats++;
         end
         if (done) break;
         tick();
         if (ram_ren) total_ren++;
      end
      total++;
      if (beats !== 8) begin bad++; $display("FAIL stall_beats: got %0d want 8", beats); end
      total++;
      if (total_ren !== 8) begin bad++; $display("FAIL stall_total_ren: got %0d want 8", total_ren); end
      tick();
   endtask

   task automatic test_strobe();
      logic [63:0] p5;
      logic [63:0] want;
      p5 = pat(5);
      want = {p5[63:32], 32'hFFFF_FFFF};
      do_write(5, 1, 8'h0F, 1'b1);
      do_read(5, 1);
      total++;
      if (got_q.size() != 1) begin bad++; $display("FAIL strb_beats: got %0d want 1", got_q.size()); end
      else begin
         total++;
         if (got_q[0] !== want) begin bad++; $display("FAIL strb_merge: got %h want %h", got_q[0], want); end
      end
   endtask

   task automatic test_err();
      int n;
      start_cmd(1'b0, 0, 0);
      total++;
      if ({err, cmd_ready, ram_ren, ram_wen} !== 4'b1100) begin
         bad++; $display("FAIL err_len0: got err/rdy/ren/wen=%b want 1100", {err, cmd_ready, ram_ren, ram_wen});
      end
      tick();
      total++;
      if ({err, ram_ren, ram_wen} !== 3'b000) begin bad++; $display("FAIL err_len0_after: got %b want 000", {err, ram_ren, ram_wen}); end
      rd_ready = 1'b1;
      start_cmd(1'b0, 510, 4);
`ifndef RAM_BURST_CTRL_WRAP_EN
      total++;
      if ({err, ram_ren, ram_wen} !== 3'b100) begin bad++; $display("FAIL err_cross: got err/ren/wen=%b want 100", {err, ram_ren, ram_wen}); end
      for (int c = 2; c <= 4; c++) begin
         tick();
         total++;
         if ({err, ram_ren, ram_wen} !== 3'b000) begin bad++; $display("FAIL err_cross_after c%0d: got %b want 000", c, {err, ram_ren, ram_wen}); end
      end
`else
      for (int c = 1; c <= 4; c++) begin
         total++;
         if (ram_ren !== 1'b1 || ram_addr !== 9'((510 + c - 1) % 512)) begin
            bad++; $display("FAIL wrap_row c%0d: got ren=%b addr=%0d want ren=1 addr=%0d", c, ram_ren, ram_addr, (510 + c - 1) % 512);
         end
         tick();
      end
      n = 0;
      while (!done && n < 30) begin tick(); n++; end
      total++;
      if (!done) begin bad++; $display("FAIL wrap_done: got 0 want 1"); end
`endif
      tick();
      // boundary: ends exactly at the last row, always legal
      start_cmd(1'b0, 508, 4);
      total++;
      if ({err, ram_ren} !== 2'b01) begin bad++; $display("FAIL edge_legal: got err/ren=%b want 01", {err, ram_ren}); end
      n = 0;
      while (!done && n < 30) begin tick(); n++; end
      total++;
      if (!done) begin bad++; $display("FAIL edge_done: got 0 want 1"); end
      tick();
   endtask

   task automatic test_reset_mid();
      int nb;
      nb = 0;
      rd_ready = 1'b1;
      start_cmd(1'b0, 16, 8);
      for (int i = 0; i < 20; i++) begin
         if (rd_valid) nb++;
         if (nb == 2) break;
         tick();
      end
      total++;
      if (nb !== 2) begin bad++; $display("FAIL mid_beat2: got %0d want 2", nb); end
      rstn = 1'b0;
      tick();
      total++;
      if ({cmd_ready, wr_ready, rd_valid, rd_last, done, err, ram_ren, ram_wen} !== 8'h00) begin
         bad++;
         $display("FAIL mid_reset_ctrl: got %b want 00000000",
                  {cmd_ready, wr_ready, rd_valid, rd_last, done, err, ram_ren, ram_wen});
      end
      total++;
      if ({ram_addr, ram_wdata, ram_wstrb, rd_data} !== '0) begin
         bad++; $display("FAIL mid_reset_buses: addr=%h rdata=%h want 0", ram_addr, rd_data);
      end
      rstn = 1'b1;
      tick();
      total++;
      if ({cmd_ready, ram_ren} !== 2'b10) begin bad++; $display("FAIL mid_release: got rdy/ren=%b want 10", {cmd_ready, ram_ren}); end
      rv_force = 1'b1;
      tick();
      rv_force = 1'b0;
      total++;
      if (rd_valid !== 1'b0 || rd_data !== '0) begin bad++; $display("FAIL mid_stray_rvalid: got v=%b d=%h want 0", rd_valid, rd_data); end
      do_read(4, 1);
      total++;
      if (got_q.size() != 1) begin bad++; $display("FAIL mid_new_cmd_beats: got %0d want 1", got_q.size()); end
      else begin
         total++;
         if (got_q[0] !== pat(4)) begin bad++; $display("FAIL mid_new_cmd_data: got %h want %h", got_q[0], pat(4)); end
      end
   endtask

   initial begin
      rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
      wr_valid = 1'b0; wr_data = '0; wr_strb = '0; rd_ready = 1'b0; rv_force = 1'b0;
      tick();
      test_reset();
      test_write();
      test_read();
      test_stall();
      test_strobe();
      test_err();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
